spi_pkt_deframer: RTL and testbench
===================================

Name: spi_pkt_deframer

Overview:
- Parametrised successor of the SPI-side input FSM.
- Consumes the deserialised word stream from the SPI host, one word per `ena` strobe.
- Hunts for a header word, then parses length, payload and XOR checksum.
- Writes payload words straight into the host RAM, then presents a packet descriptor that is held until acknowledged.
- Sits between the SPI deserializer and the RAM host.

Parameters:
- DATA_W, 8: stream word width; also the width of the length and checksum fields.
- HEADER, 8'hA5: header word value. Width is DATA_W.
- ADDR_W, 8: RAM write-address width.
- MAX_LEN, 255: largest accepted payload length in words. Must satisfy MAX_LEN ≤ 2^ADDR_W and MAX_LEN ≤ 2^DATA_W-1.
- TIMEOUT, 255: idle cycles without `ena` that abort an in-progress packet. Must be ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_a  in  1  asynchronous reset, active-high.
- ena  in  1  `src` valid this cycle. The stream cannot be stalled.
- src  in  DATA_W  stream word.
- ready  out  1  high in IDLE (hunting for header).
- wr_en  out  1  RAM write strobe, one cycle per payload word.
- wr_addr  out  ADDR_W  payload index; the first payload word is written at 0.
- wr_data  out  DATA_W  payload word.
- pkt_valid  out  1  descriptor valid; held until `pkt_ack`.
- pkt_ok  out  1  checksum matched. Valid while `pkt_valid`.
- pkt_len  out  DATA_W  payload length. Valid while `pkt_valid`.
- pkt_ack  in  1  consumer releases the descriptor.
- err_len  out  1  one-cycle pulse: length > MAX_LEN.
- err_timeout  out  1  one-cycle pulse: inter-word gap reached TIMEOUT.
- overrun  out  1  one-cycle pulse: word arrived while the descriptor was pending.

Behaviour:
- Reset (`rst_a`=1, async): state IDLE. All outputs, counters and the accumulator are 0; `ready` is 1. A packet interrupted by reset produces no `pkt_valid` and no further writes.
- All outputs are registered. Every response appears the cycle after the `ena` word that causes it.
- States: IDLE, LEN, PAYLOAD, CHK, DONE. All transitions below happen on a cycle with `ena`=1 unless noted.
- IDLE:
  - `src`==HEADER → LEN.
  - Any other word is discarded silently.
- LEN:
  - Load `len`=`src` and `acc`=`src`.
  - `src`==0 → CHK.
  - `src`>MAX_LEN → pulse `err_len`, go to IDLE.
  - Otherwise → PAYLOAD, with `cnt`=0.
- PAYLOAD:
  - Issue `wr_en`=1, `wr_addr`=`cnt`, `wr_data`=`src`.
  - Update `acc` ^= `src` and increment `cnt`.
  - When `cnt`==`len`-1 → CHK.
- CHK:
  - Set `pkt_valid`=1, `pkt_ok`=(`src`==`acc`), `pkt_len`=`len` → DONE.
  - A failed checksum still produces a descriptor. Its payload is already in RAM; the consumer discards it.
- DONE:
  - `pkt_valid` is held; `ready`=0.
  - `pkt_ack`=1 → clear `pkt_valid`, `pkt_ok` and `pkt_len` next cycle, go to IDLE.
  - `ena` without `pkt_ack` → pulse `overrun`, word discarded.
  - `ena` together with `pkt_ack` → go to IDLE, word discarded, no `overrun`.
  - `pkt_ack` outside DONE is ignored.
- Timeout:
  - An idle counter runs in LEN, PAYLOAD and CHK. It resets on every `ena` and on state entry, and increments on each cycle with `ena`=0.
  - Reaching TIMEOUT → pulse `err_timeout`, go to IDLE, no descriptor.
  - Words already written stay in RAM.
  - The counter is inactive in IDLE and DONE.
- Header value inside length or payload has no special meaning; there is no resync mid-packet.
- The checksum is the XOR of the length word and all payload words. Width is DATA_W; there is no carry.
- `wr_addr` never wraps, because MAX_LEN ≤ 2^ADDR_W.
- `wr_en` is 0 in every state except the cycle after a PAYLOAD word.

Test Plan:
- Good packet: stream A5 03 11 22 33 03 → writes (0,11), (1,22), (2,33); then `pkt_valid`=1, `pkt_ok`=1, `pkt_len`=3 until `pkt_ack`; then `ready`=1.
- Bad checksum and zero length: A5 03 11 22 33 04 → three writes, `pkt_ok`=0. After ack, A5 00 00 → no writes, `pkt_ok`=1, `pkt_len`=0.
- Junk before header and gapped `ena`: 00 FF 5A A5 01 7E 7F, with 3 idle cycles between words → single write (0,7E), `pkt_ok`=1.
- Length limit and timeout:
  - MAX_LEN=4: A5 05 → `err_len` pulse, IDLE, no writes.
  - TIMEOUT=16: A5 02 11, then 16 cycles without `ena` → `err_timeout` pulse on the 16th cycle, IDLE, no `pkt_valid`.
- Overrun and simultaneous ack:
  - Second packet A5 01 … while `pkt_valid` is held → `overrun` pulses per word, no writes, descriptor unchanged.
  - `pkt_ack` in the same cycle as `ena`=A5 → IDLE, no `overrun`, that header is not detected.
- Reset mid-payload: assert `rst_a` after A5 04 11 22 → all outputs 0 immediately. After release, A5 01 7E 7F completes normally with the write at address 0.

Source files
------------

// File: rtl/spi_pkt_deframer.sv
// Packet deframer for the SPI word stream: header hunt, length/payload/checksum parse,
// direct RAM writes of the payload and a held packet descriptor.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | hunting for HEADER, ready=1
// S_LEN     | next word is the payload length
// S_PAYLOAD | payload words written to RAM, acc folds in each word
// S_CHK     | next word is the XOR checksum
// S_DONE    | descriptor held until pkt_ack
module spi_pkt_deframer #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] HEADER  = 8'hA5,
    parameter int                ADDR_W  = 8,
    parameter int                MAX_LEN = 255,
    parameter int                TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              ena,
    input  logic [DATA_W-1:0] src,
    output logic              ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              pkt_valid,
    output logic              pkt_ok,
    output logic [DATA_W-1:0] pkt_len,
    input  logic              pkt_ack,
    output logic              err_len,
    output logic              err_timeout,
    output logic              overrun
);

    localparam int CNT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] MAX_LEN_W = DATA_W'(MAX_LEN);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] len_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TO_W-1:0]   idle_q;
    logic              in_pkt;
    logic              cnt_last;

    assign in_pkt   = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    // cnt is kept wide enough to compare against len without truncation
    assign cnt_last = (cnt_q + CNT_W'(1)) == CNT_W'(len_q);

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state       <= S_IDLE;
            len_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            ready       <= 1'b1;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            pkt_valid   <= 1'b0;
            pkt_ok      <= 1'b0;
            pkt_len     <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;

            if (in_pkt && !ena) begin
                if (idle_q == TO_LAST) begin
                    err_timeout <= 1'b1;
                    state       <= S_IDLE;
                    ready       <= 1'b1;
                end else begin
                    idle_q <= idle_q + TO_W'(1);
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ena && src == HEADER) begin
                            state  <= S_LEN;
                            ready  <= 1'b0;
                            idle_q <= '0;
                        end
                    end
                    S_LEN: begin
                        idle_q <= '0;
                        len_q  <= src;
                        acc_q  <= src;
                        if (src == '0) begin
                            state <= S_CHK;
                        end else if (src > MAX_LEN_W) begin
                            err_len <= 1'b1;
                            state   <= S_IDLE;
                            ready   <= 1'b1;
                        end else begin
                            cnt_q <= '0;
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        idle_q  <= '0;
                        wr_en   <= 1'b1;
                        wr_addr <= cnt_q[ADDR_W-1:0];
                        wr_data <= src;
                        acc_q   <= acc_q ^ src;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_last) begin
                            state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        idle_q    <= '0;
                        pkt_valid <= 1'b1;
                        pkt_ok    <= (src == acc_q);
                        pkt_len   <= len_q;
                        state     <= S_DONE;
                    end
                    S_DONE: begin
                        // an ack wins over a concurrent word, which is dropped silently
                        if (pkt_ack) begin
                            pkt_valid <= 1'b0;
                            pkt_ok    <= 1'b0;
                            pkt_len   <= '0;
                            state     <= S_IDLE;
                            ready     <= 1'b1;
                        end else if (ena) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_pkt_deframer.sv
// Scoreboard bench for spi_pkt_deframer: packet-level reference model feeds an
// expected-event queue, a negedge monitor pops and compares every DUT response.
module tb_spi_pkt_deframer;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int ML  = 4;
    localparam int TO  = 16;
    localparam logic [7:0] HDR = 8'hA5;

    localparam int K_WR   = 0;
    localparam int K_DESC = 1;
    localparam int K_ELEN = 2;
    localparam int K_ETO  = 3;
    localparam int K_OVR  = 4;

    logic          clk;
    logic          rst_a;
    logic          ena;
    logic [DW-1:0] src;
    logic          ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          pkt_valid;
    logic          pkt_ok;
    logic [DW-1:0] pkt_len;
    logic          pkt_ack;
    logic          err_len;
    logic          err_timeout;
    logic          overrun;

    spi_pkt_deframer #(
        .DATA_W (DW),
        .HEADER (HDR),
        .ADDR_W (AW),
        .MAX_LEN(ML),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .ena        (ena),
        .src        (src),
        .ready      (ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pkt_valid  (pkt_valid),
        .pkt_ok     (pkt_ok),
        .pkt_len    (pkt_len),
        .pkt_ack    (pkt_ack),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] pl[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input int a, input int b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int k, input int a, input int b, output ev_t e);
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", k, -1);
            e.kind = -1;
            e.a    = a;
            e.b    = b;
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_field_a", a, e.a);
            check("event_field_b", b, e.b);
        end
    endtask

    // monitor: every response of the DUT must match the head of the expected queue
    logic pv_d = 1'b0;
    int   hold_len = 0;
    int   hold_ok = 0;
    always @(negedge clk) begin
        ev_t e;
        if (rst_a) begin
            pv_d = 1'b0;
        end else begin
            if (wr_en) pop_cmp(K_WR, wr_addr, wr_data, e);
            if (pkt_valid && !pv_d) begin
                pop_cmp(K_DESC, pkt_len, pkt_ok, e);
                hold_len = e.a;
                hold_ok  = e.b;
            end else if (pkt_valid) begin
                check("desc_hold_len", pkt_len, hold_len);
                check("desc_hold_ok", pkt_ok, hold_ok);
            end
            if (err_len)     pop_cmp(K_ELEN, 0, 0, e);
            if (err_timeout) pop_cmp(K_ETO, 0, 0, e);
            if (overrun)     pop_cmp(K_OVR, 0, 0, e);
            pv_d = pkt_valid;
        end
    end

    task automatic cyc(input logic e, input logic [7:0] s, input logic a);
        ena     = e;
        src     = s;
        pkt_ack = a;
        @(posedge clk);
        #1;
        ena     = 1'b0;
        pkt_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic word(input logic [7:0] s, input int gap, input bit noise);
        repeat (gap) cyc(1'b0, 8'h00, noise ? 1'($urandom_range(1)) : 1'b0);
        cyc(1'b1, s, noise ? 1'($urandom_range(1)) : 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_pkt_valid"}, pkt_valid, 0);
        check({tag, "_pkt_ok"}, pkt_ok, 0);
        check({tag, "_pkt_len"}, pkt_len, 0);
        check({tag, "_err_len"}, err_len, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    // Packet-level model: writes at 0..len-1, checksum = XOR of length and payload.
    task automatic send_pkt(input int len, input logic [7:0] chkv, input int gap,
                            input int n_over, input bit ack_ena, input bit noise);
        logic [7:0] x;
        if (len > ML) begin
            push(K_ELEN, 0, 0);
        end else begin
            x = 8'(len);
            for (int i = 0; i < len; i++) begin
                push(K_WR, i, pl[i]);
                x = x ^ pl[i];
            end
            push(K_DESC, len, (chkv == x) ? 1 : 0);
            for (int i = 0; i < n_over; i++) push(K_OVR, 0, 0);
        end

        word(HDR, gap, noise);
        word(8'(len), gap, noise);
        if (len > ML) begin
            check("ready_after_err_len", ready, 1);
            return;
        end
        for (int i = 0; i < len; i++) word(pl[i], gap, noise);
        word(chkv, gap, 1'b0);
        check("valid_after_chk", pkt_valid, 1);
        check("ready_in_done", ready, 0);
        for (int i = 0; i < n_over; i++) begin
            idle($urandom_range(2));
            cyc(1'b1, 8'($urandom), 1'b0);
        end
        idle($urandom_range(2));
        check("valid_before_ack", pkt_valid, 1);
        cyc(ack_ena, HDR, 1'b1);
        check("ready_after_ack", ready, 1);
        check("valid_after_ack", pkt_valid, 0);
        check("len_cleared", pkt_len, 0);
        check("ok_cleared", pkt_ok, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        int         len;
        rst_a   = 1'b1;
        ena     = 1'b0;
        src     = 8'h00;
        pkt_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_a = 1'b0;
        idle(2);

        // good packet
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_pkt(3, 8'h03, 0, 0, 1'b0, 1'b0);
        // bad checksum, then zero-length packet
        send_pkt(3, 8'h04, 0, 0, 1'b0, 1'b0);
        send_pkt(0, 8'h00, 0, 0, 1'b0, 1'b0);

        // junk before header with gapped ena
        word(8'h00, 3, 1'b0);
        word(8'hFF, 3, 1'b0);
        word(8'h5A, 3, 1'b0);
        check("ready_after_junk", ready, 1);
        pl[0] = 8'h7E;
        send_pkt(1, 8'h7F, 3, 0, 1'b0, 1'b0);

        // length over limit
        send_pkt(5, 8'h00, 0, 0, 1'b0, 1'b0);

        // timeout mid-payload
        push(K_WR, 0, 8'h11);
        push(K_ETO, 0, 0);
        word(HDR, 0, 1'b0);
        word(8'h02, 0, 1'b0);
        word(8'h11, 0, 1'b0);
        idle(TO - 1);
        check("timeout_not_early", err_timeout, 0);
        check("ready_before_timeout", ready, 0);
        idle(1);
        check("timeout_pulse", err_timeout, 1);
        check("ready_after_timeout", ready, 1);
        idle(1);
        check("timeout_one_cycle", err_timeout, 0);
        check("no_desc_after_timeout", pkt_valid, 0);

        // overrun while descriptor pending, ack together with a header word
        pl[0] = 8'h7E;
        send_pkt(1, 8'h7F, 0, 3, 1'b1, 1'b0);
        cyc(1'b1, 8'h01, 1'b0);
        check("header_with_ack_ignored", ready, 1);

        // reset mid-payload
        push(K_WR, 0, 8'h11);
        push(K_WR, 1, 8'h22);
        word(HDR, 0, 1'b0);
        word(8'h04, 0, 1'b0);
        word(8'h11, 0, 1'b0);
        word(8'h22, 0, 1'b0);
        @(negedge clk);
        #1;
        rst_a = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        idle(1);
        pl[0] = 8'h7E;
        send_pkt(1, 8'h7F, 0, 0, 1'b0, 1'b0);

        // randomized packets
        for (int n = 0; n < 40; n++) begin
            for (int j = $urandom_range(2); j > 0; j--) begin
                x = 8'($urandom);
                if (x == HDR) x = 8'h00;
                word(x, $urandom_range(3), 1'b1);
            end
            len = $urandom_range(ML + 1);
            x = 8'(len);
            for (int i = 0; i < len; i++) begin
                pl[i] = 8'($urandom);
                x = x ^ pl[i];
            end
            if ($urandom_range(1) == 0) x = 8'($urandom);
            send_pkt(len, x, $urandom_range(3), $urandom_range(2),
                     1'($urandom_range(1)), 1'b1);
        end

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
        idle(3);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
